// File: rtl/pipeline_ctrl.sv
// Hazard controller for a 5-stage pipeline: forwarding selects, load-use and
// mul/div stalls, fetch-wait handling, and stall/flush activity counters.
module pipeline_ctrl #(
   parameter int MD_TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  Rs1D,
   input  logic [4:0]  Rs2D,
   input  logic [4:0]  Rs1E,
   input  logic [4:0]  Rs2E,
   input  logic [4:0]  RdE,
   input  logic [4:0]  RdM,
   input  logic [4:0]  RdW,
   input  logic        RegWriteM,
   input  logic        RegWriteW,
   input  logic        LoadE,
   input  logic        PCSrcE,
   input  logic        md_start_E,
   input  logic        md_done,
   input  logic        imem_valid,
   output logic        StallF,
   output logic        StallD,
   output logic        StallE,
   output logic        FlushD,
   output logic        FlushE,
   output logic        FlushM,
   output logic [1:0]  ForwardAE,
   output logic [1:0]  ForwardBE,
   output logic        imem_abort,
   output logic        md_timeout,
   output logic [31:0] stall_cycles,
   output logic [15:0] flush_count
);

   // state     | meaning
   // RUN       | normal issue; load-use and branch hazards handled here
   // MD_WAIT   | back end frozen until mul/div result or timeout
   // IMEM_WAIT | fetch data outstanding; decode receives bubbles
   typedef enum logic [1:0] {
      S_RUN       = 2'd0,
      S_MD_WAIT   = 2'd1,
      S_IMEM_WAIT = 2'd2
   } state_t;

   localparam int CW = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
   localparam logic [CW-1:0] MD_LAST = CW'(MD_TIMEOUT - 1);

   state_t          r_state;
   logic [CW-1:0]   r_md_cnt;
   logic [31:0]     r_stall_cycles;
   logic [15:0]     r_flush_count;

   logic            w_lw_stall;
   logic            w_md_issue;
   logic            w_md_expire;
   logic            w_stall_f;
   logic            w_stall_d;
   logic            w_stall_e;
   logic            w_flush_d;
   logic            w_flush_e;
   logic            w_flush_m;
   logic            w_abort;
   logic            w_timeout;
   logic [1:0]      w_fwd_a;
   logic [1:0]      w_fwd_b;

   assign w_lw_stall  = LoadE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
   assign w_md_issue  = (r_state == S_RUN) && md_start_E && !md_done;
   assign w_md_expire = (r_state == S_MD_WAIT) && !md_done && (r_md_cnt == MD_LAST);

   always_comb begin
      w_fwd_a = 2'b00;
      w_fwd_b = 2'b00;
      if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E))
         w_fwd_a = 2'b10;
      else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E))
         w_fwd_a = 2'b01;
      if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E))
         w_fwd_b = 2'b10;
      else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E))
         w_fwd_b = 2'b01;
   end

   always_comb begin
      w_stall_f = 1'b0;
      w_stall_d = 1'b0;
      w_stall_e = 1'b0;
      w_flush_d = 1'b0;
      w_flush_e = 1'b0;
      w_flush_m = 1'b0;
      w_abort   = 1'b0;
      w_timeout = 1'b0;
      case (r_state)
         S_MD_WAIT: begin
            // done and expiry both release the pipe; done suppresses the timeout flag
            if (w_md_expire) begin
               w_timeout = 1'b1;
            end else if (!md_done) begin
               w_stall_f = 1'b1;
               w_stall_d = 1'b1;
               w_stall_e = 1'b1;
               w_flush_m = 1'b1;
            end
         end
         S_IMEM_WAIT: begin
            if (PCSrcE) begin
               w_flush_d = 1'b1;
               w_flush_e = 1'b1;
               w_abort   = 1'b1;
            end else begin
               w_stall_f = 1'b1;
               w_stall_d = w_lw_stall;
               w_flush_d = !w_lw_stall;
               w_flush_e = w_lw_stall;
            end
         end
         default: begin
            if (w_md_issue) begin
               w_stall_f = 1'b1;
               w_stall_d = 1'b1;
               w_stall_e = 1'b1;
               w_flush_m = 1'b1;
            end else begin
               w_stall_f = w_lw_stall;
               w_stall_d = w_lw_stall;
               w_flush_e = w_lw_stall | PCSrcE;
               w_flush_d = PCSrcE & ~w_lw_stall;
            end
         end
      endcase
   end

   // Reset presents a fully flushed, unstalled pipe regardless of state.
   always_comb begin
      if (!rst_n) begin
         StallF     = 1'b0;
         StallD     = 1'b0;
         StallE     = 1'b0;
         FlushD     = 1'b1;
         FlushE     = 1'b1;
         FlushM     = 1'b1;
         ForwardAE  = 2'b00;
         ForwardBE  = 2'b00;
         imem_abort = 1'b0;
         md_timeout = 1'b0;
      end else begin
         StallF     = w_stall_f;
         StallD     = w_stall_d;
         StallE     = w_stall_e;
         FlushD     = w_flush_d;
         FlushE     = w_flush_e;
         FlushM     = w_flush_m;
         ForwardAE  = w_fwd_a;
         ForwardBE  = w_fwd_b;
         imem_abort = w_abort;
         md_timeout = w_timeout;
      end
   end

   assign stall_cycles = r_stall_cycles;
   assign flush_count  = r_flush_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= S_RUN;
         r_md_cnt       <= '0;
         r_stall_cycles <= '0;
         r_flush_count  <= '0;
      end else begin
         case (r_state)
            S_MD_WAIT: begin
               if (md_done || w_md_expire)
                  r_state <= S_RUN;
               else
                  r_md_cnt <= r_md_cnt + CW'(1);
            end
            S_IMEM_WAIT: begin
               if (PCSrcE || imem_valid)
                  r_state <= S_RUN;
            end
            default: begin
               if (w_md_issue) begin
                  r_state  <= S_MD_WAIT;
                  r_md_cnt <= '0;
               end else if (!imem_valid) begin
                  r_state <= S_IMEM_WAIT;
               end
            end
         endcase
         if (w_stall_d && (r_stall_cycles != 32'hFFFF_FFFF))
            r_stall_cycles <= r_stall_cycles + 32'd1;
         if (w_flush_d || w_flush_e)
            r_flush_count <= r_flush_count + 16'd1;
      end
   end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter MD_TIMEOUT, default 64, max cycles waited for a multiply/divide result.
REQ-002 SHALL have ports (name  direction  width  meaning):
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- Rs1D, Rs2D  in  5  decode-stage source registers
- Rs1E, Rs2E, RdE  in  5  execute-stage sources/destination
- RdM, RdW  in  5  memory/writeback destinations
- RegWriteM, RegWriteW  in  1  M/W stage writes register file
- LoadE  in  1  instruction in E is a load
- PCSrcE  in  1  branch/jump taken in E
- md_start_E  in  1  mul/div issued in E this cycle
- md_done  in  1  mul/div result ready
- imem_valid  in  1  instruction fetch data valid
- StallF, StallD, StallE  out  1  hold PC / IF-ID / ID-EX registers
- FlushD, FlushE, FlushM  out  1  insert NOP into IF-ID / ID-EX / EX-MEM
- ForwardAE, ForwardBE  out  2  operand mux select: 00 regfile, 01 W, 10 M
- imem_abort  out  1  discard outstanding fetch
- md_timeout  out  1  one-cycle pulse on mul/div timeout
- stall_cycles  out  32  saturating count of cycles with StallD=1
- flush_count  out  16  wrapping count of cycles with FlushD|FlushE=1

Function
REQ-003 SHALL implement FSM states RUN, MD_WAIT, IMEM_WAIT.
REQ-004 ForwardAE SHALL be 10 if RegWriteM and RdM!=0 and RdM==Rs1E; else 01 if RegWriteW and RdW!=0 and RdW==Rs1E; else 00 (ForwardBE same with Rs2E); combinational, valid in every state.
REQ-005 lwStall SHALL be LoadE and RdE!=0 and (RdE==Rs1D or RdE==Rs2D).
REQ-006 Stall/flush outputs SHALL be combinational from inputs and registered state; all state registered.
REQ-007 RUN: StallF=StallD=lwStall; FlushE=lwStall|PCSrcE; FlushD=PCSrcE & ~lwStall; StallE=FlushM=0.
REQ-008 RUN -> MD_WAIT when md_start_E=1 and md_done=0; that cycle SHALL already assert StallF/D/E=1, FlushM=1, FlushD=FlushE=0 (overrides REQ-007).
REQ-009 MD_WAIT: StallF/D/E=1, FlushM=1, FlushD=FlushE=0, PCSrcE and lwStall ignored.
REQ-010 MD_WAIT exit on md_done=1: that cycle all stalls and FlushM=0; next state RUN.
REQ-011 Wait counter SHALL clear on MD_WAIT entry and increment each MD_WAIT cycle; when it equals MD_TIMEOUT-1 without md_done, md_timeout=1 for that cycle, stalls released, next state RUN.
REQ-012 md_done and timeout in the same cycle: md_done wins, md_timeout=0.
REQ-013 RUN -> IMEM_WAIT when imem_valid=0 and no MD condition; lwStall/PCSrcE rules of REQ-007 still apply that cycle.
REQ-014 IMEM_WAIT: StallF=1, FlushD=1 (unless lwStall, then StallD=1, FlushD=0); exit to RUN on imem_valid=1.
REQ-015 IMEM_WAIT with PCSrcE=1: FlushD=FlushE=1, StallF=0, imem_abort=1 for one cycle, next state RUN; PCSrcE takes priority over imem_valid.
REQ-016 imem_abort SHALL be 0 in all other cases.
REQ-017 stall_cycles SHALL increment each cycle StallD=1, saturating at 32'hFFFFFFFF.
REQ-018 flush_count SHALL increment each cycle FlushD|FlushE=1, wrapping 16'hFFFF -> 0.

Reset
REQ-019 rst_n=0 SHALL immediately force state RUN, wait counter 0, stall_cycles 0, flush_count 0, md_timeout 0, imem_abort 0.
REQ-020 While rst_n=0: StallF/D/E=0, FlushD=FlushE=FlushM=1, ForwardAE=ForwardBE=00.
REQ-021 Reset asserted in MD_WAIT or IMEM_WAIT SHALL abandon the wait; first cycle after release is RUN.

Verification
REQ-022 Load-use: LoadE=1, RdE=5, Rs1D=5 -> StallF=StallD=1, FlushE=1, FlushD=0 one cycle; stall_cycles +1.
REQ-023 Forward priority: RegWriteM=RegWriteW=1, RdM=RdW=Rs1E=7 -> ForwardAE=10; Rs1E=RdM=RdW=0 -> 00.
REQ-024 Mul/div: md_start_E=1, md_done after 5 cycles -> StallE=1 and FlushM=1 for 5 cycles, released on md_done cycle; md_done never, MD_TIMEOUT=8 -> md_timeout pulse on 8th cycle, then RUN.
REQ-025 Branch during fetch wait: imem_valid=0 two cycles, PCSrcE=1 in 2nd -> imem_abort=1, FlushD=FlushE=1, StallF=0 that cycle; RUN next.
REQ-026 Reset mid MD_WAIT: rst_n=0 at cycle 3 -> stalls drop immediately, flushes=1, counters 0; after release StallE=0.
REQ-027 Counter limits: preload stall_cycles=32'hFFFFFFFF, stall -> stays; flush_count=16'hFFFF, flush -> 0.
